// File: rtl/joy_pkg.sv
// Shared types and sizing helpers for the DB15 joystick shift-chain transmitter.
package joy_pkg;

    localparam int PLAYER_BITS_DEF = 12;
    localparam int FILT_CYC_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int chain_len(input int player_bits);
        return 2 * player_bits;
    endfunction

    function automatic int cnt_width(input int player_bits);
        return $clog2(2 * player_bits + 1);
    endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// Pin-level bundle between the DB15 receiver (master) and the device-side chain model (slave).
interface joy_db15_tx_if;
    import joy_pkg::*;

    // Protocol: the master holds JOY_LOAD low to capture both button words, releases it,
    // then each JOY_CLK rise advances the chain by one bit; JOY_DATA shows the current bit.
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    state_t      state;

    modport master (
        output joystick1, joystick2, JOY_CLK, JOY_LOAD,
        input  JOY_DATA, busy, frame_done, frame_err, state
    );

    modport slave (
        input  joystick1, joystick2, JOY_CLK, JOY_LOAD,
        output JOY_DATA, busy, frame_done, frame_err, state
    );

endinterface

// File: rtl/joy_sync_edge.sv
// Two-flop synchroniser plus stability filter; emits the filtered level and one-cycle rise/fall strobes.
module joy_sync_edge #(
    parameter int   FILT_CYC = 2,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    logic          s1;
    logic          s2;
    logic [FW-1:0] stab;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= RST_VAL;
            s2    <= RST_VAL;
            stab  <= '0;
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            // A new level is accepted only after FILT_CYC consecutive cycles of disagreement.
            if (s2 == level) begin
                stab <= '0;
            end else if (stab == FW'(FILT_CYC - 1)) begin
                level <= s2;
                rise  <= s2;
                fall  <= ~s2;
                stab  <= '0;
            end else begin
                stab <= stab + 1'b1;
            end
        end
    end

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick adapter: dual 74HC165-style chain, loaded on JOY_LOAD low, shifted on JOY_CLK rise.
module joy_db15_tx
    import joy_pkg::*;
#(
    parameter int PLAYER_BITS = PLAYER_BITS_DEF,
    parameter int FILT_CYC    = FILT_CYC_DEF
) (
    input logic          clk,
    input logic          reset_n,
    joy_db15_tx_if.slave bus
);
    localparam int CHAIN_LEN = chain_len(PLAYER_BITS);
    localparam int CW        = cnt_width(PLAYER_BITS);

    logic                 clk_rise;
    logic                 load_lvl;
    logic                 load_rise;
    logic                 unused_clk_lvl;
    logic                 unused_clk_fall;
    logic                 unused_load_fall;
    logic [CHAIN_LEN-1:0] sr;
    logic [CHAIN_LEN-1:0] load_vec;
    logic [CW-1:0]        cnt;
    state_t               state_q;
    state_t               state_nx;
    logic                 done_q;
    logic                 done_nx;
    logic                 err_q;
    logic                 err_nx;

    joy_sync_edge #(.FILT_CYC(FILT_CYC), .RST_VAL(1'b0)) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.JOY_CLK),
        .level   (unused_clk_lvl),
        .rise    (clk_rise),
        .fall    (unused_clk_fall)
    );

    joy_sync_edge #(.FILT_CYC(FILT_CYC), .RST_VAL(1'b1)) u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.JOY_LOAD),
        .level   (load_lvl),
        .rise    (load_rise),
        .fall    (unused_load_fall)
    );

    if (PLAYER_BITS < 16) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{bus.joystick1[15:PLAYER_BITS], bus.joystick2[15:PLAYER_BITS]};
    end

    // Buttons are active-high at the ports but the chain carries them active-low.
    assign load_vec = {~bus.joystick2[PLAYER_BITS-1:0], ~bus.joystick1[PLAYER_BITS-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '1;
            cnt <= '0;
        end else if (!load_lvl) begin
            sr  <= load_vec;
            cnt <= '0;
        end else if (clk_rise && !load_rise) begin
            sr <= {1'b1, sr[CHAIN_LEN-1:1]};
            if (cnt != CW'(CHAIN_LEN)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state_q)
            IDLE:  if (!load_lvl) state_nx = LOAD;
            LOAD:  if (load_lvl)  state_nx = SHIFT;
            SHIFT: begin
                if (!load_lvl) begin
                    state_nx = LOAD;
                    err_nx   = 1'b1;
                end else if (cnt == CW'(CHAIN_LEN)) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end
            end
            DONE:  if (!load_lvl) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
        end
    end

    assign bus.JOY_DATA   = sr[0];
    assign bus.busy       = (state_q == SHIFT);
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: acts as the DB15 receiver, reading frames bit by bit and scoring them.
module tb_joy_db15_tx;
    import joy_pkg::*;

    localparam int W = 24;

    typedef struct {
        logic [15:0]  j1;
        logic [15:0]  j2;
        logic [W-1:0] exp_word;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           err_cnt = 0;
    logic [W-1:0] exp_q[$];
    vec_t         vecs[5];

    joy_db15_tx_if bus();

    joy_db15_tx #(.PLAYER_BITS(12), .FILT_CYC(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // clock / reset
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.frame_done) done_cnt++;
            if (bus.frame_err)  err_cnt++;
        end
    end

    // reference: bit i of the stream is player1 bit i then player2, inverted
    function automatic logic [W-1:0] model_frame(input logic [15:0] j1, input logic [15:0] j2);
        logic [W-1:0] w;
        logic pressed;
        for (int i = 0; i < W; i++) begin
            pressed = (i < 12) ? j1[i] : j2[i-12];
            w[i] = ~pressed;
        end
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic clk_pulse();
        bus.JOY_CLK = 1'b1;
        cyc(8);
        bus.JOY_CLK = 1'b0;
        cyc(8);
    endtask

    task automatic load_pulse();
        bus.JOY_LOAD = 1'b0;
        cyc(8);
        bus.JOY_LOAD = 1'b1;
        cyc(8);
    endtask

    task automatic read_frame(input int glitch_at, output logic [W-1:0] word);
        logic d0;
        for (int i = 0; i < W; i++) begin
            if (i == glitch_at) begin
                d0 = bus.JOY_DATA;
                bus.JOY_CLK = 1'b1;
                cyc(1);
                bus.JOY_CLK = 1'b0;
                bus.joystick1 = ~bus.joystick1;
                cyc(10);
                check("glitch_hold", {31'd0, bus.JOY_DATA}, {31'd0, d0});
            end
            word[i] = bus.JOY_DATA;
            clk_pulse();
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] j1, input logic [15:0] j2,
                             input int glitch_at);
        int d0;
        int e0;
        logic [W-1:0] word;
        logic [W-1:0] exp;
        bus.joystick1 = j1;
        bus.joystick2 = j2;
        d0 = done_cnt;
        e0 = err_cnt;
        load_pulse();
        check({name, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
        read_frame(glitch_at, word);
        exp = exp_q.pop_front();
        check({name, "_stream"}, {8'd0, word}, {8'd0, exp});
        check({name, "_done_once"}, done_cnt - d0, 32'd1);
        check({name, "_no_err"}, err_cnt - e0, 32'd0);
        check({name, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        logic [W-1:0] word;
        logic [15:0] r1;
        logic [15:0] r2;

        vecs[0] = '{j1: 16'h0001, j2: 16'h0000, exp_word: 24'hFFFFFE};
        vecs[1] = '{j1: 16'h0000, j2: 16'h0800, exp_word: 24'h7FFFFF};
        vecs[2] = '{j1: 16'h0FFF, j2: 16'h0000, exp_word: 24'hFFF000};
        vecs[3] = '{j1: 16'h0A5A, j2: 16'h03C3, exp_word: 24'hC3C5A5};
        vecs[4] = '{j1: 16'hF000, j2: 16'hF123, exp_word: 24'hEDCFFF};

        bus.joystick1 = 16'h0;
        bus.joystick2 = 16'h0;
        bus.JOY_CLK   = 1'b0;
        bus.JOY_LOAD  = 1'b1;
        reset_n       = 1'b0;
        cyc(4);
        check("rst_data", {31'd0, bus.JOY_DATA}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_state", {30'd0, bus.state}, {30'd0, IDLE});
        repeat (10) clk_pulse();
        check("rst_hold_data", {31'd0, bus.JOY_DATA}, 32'd1);
        check("rst_hold_busy", {31'd0, bus.busy}, 32'd0);
        reset_n = 1'b1;
        cyc(4);

        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].exp_word);
            run_frame($sformatf("vec%0d", v), vecs[v].j1, vecs[v].j2, -1);
        end

        // over-clocking past the chain end shifts in idle ones
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("over_bit%0d", 24 + i), {31'd0, bus.JOY_DATA}, 32'd1);
            clk_pulse();
        end
        check("over_no_done", done_cnt - d0, 32'd0);
        check("over_no_err", err_cnt - e0, 32'd0);

        // short frame interrupted by a new load
        bus.joystick1 = 16'h0123;
        bus.joystick2 = 16'h0000;
        load_pulse();
        repeat (10) clk_pulse();
        e0 = err_cnt;
        bus.JOY_LOAD = 1'b0;
        cyc(8);
        check("short_err_once", err_cnt - e0, 32'd1);
        check("short_busy_load", {31'd0, bus.busy}, 32'd0);
        check("short_state", {30'd0, bus.state}, {30'd0, LOAD});
        bus.joystick1 = 16'h0456;
        bus.joystick2 = 16'h0789;
        cyc(8);
        bus.JOY_LOAD = 1'b1;
        cyc(8);
        read_frame(-1, word);
        check("short_restart", {8'd0, word}, {8'd0, model_frame(16'h0456, 16'h0789)});

        // glitch on JOY_CLK plus player1 change mid-frame
        exp_q.push_back(model_frame(16'h00F0, 16'h0A0A));
        run_frame("glitch", 16'h00F0, 16'h0A0A, 7);

        // randomized frames against the model
        for (int n = 0; n < 30; n++) begin
            r1 = 16'($urandom_range(0, 16'hFFFF));
            r2 = 16'($urandom_range(0, 16'hFFFF));
            exp_q.push_back(model_frame(r1, r2));
            run_frame($sformatf("rnd%0d", n), r1, r2, -1);
        end

        // reset mid-frame; no frame until a fresh load
        bus.joystick1 = 16'h0FFF;
        bus.joystick2 = 16'h0FFF;
        load_pulse();
        repeat (5) clk_pulse();
        reset_n = 1'b0;
        cyc(2);
        check("midrst_data", {31'd0, bus.JOY_DATA}, 32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_state", {30'd0, bus.state}, {30'd0, IDLE});
        reset_n = 1'b1;
        cyc(4);
        d0 = done_cnt;
        for (int i = 0; i < 26; i++) begin
            word[i % W] = bus.JOY_DATA;
            clk_pulse();
        end
        check("midrst_idle_ones", {8'd0, word}, 32'h00FFFFFF);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_busy_after", {31'd0, bus.busy}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
